// File: rtl/lsu_mem.sv
// lsu_mem: data-side load/store unit driving a single-word valid/ready memory port
module lsu_mem #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, ERR = 2'd2;
  logic [1:0]  state;
  logic [31:0] cnt;
  logic        st, uns, bad, tmo;
  logic [1:0]  sz, off;
  logic [31:0] wd, sh, ld;
  logic [3:0]  ws;
  assign req_ready = state == IDLE;
  assign mem_instr = 1'b0;
  // request decode, store lane replication and load lane extraction
  always_comb begin
    bad = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
    wd  = req_size == 2'd0 ? {4{req_wdata[7:0]}} : req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    ws  = req_size == 2'd0 ? 4'b0001 << req_addr[1:0] : req_size == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'hF;
    sh  = mem_rdata >> {off, 3'b000};
    ld  = sz == 2'd0 ? {{24{~uns & sh[7]}}, sh[7:0]} : sz == 2'd1 ? {{16{~uns & sh[15]}}, sh[15:0]} : sh;
    tmo = TIMEOUT != 0 && cnt + 32'd1 >= 32'(TIMEOUT);
  end
  // access sequencing: issue, wait for completion or watchdog, respond
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      st         <= 1'b0;
      sz         <= 2'd0;
      uns        <= 1'b0;
      off        <= 2'd0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      mem_valid  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          st    <= req_store;
          sz    <= req_size;
          uns   <= req_unsigned;
          off   <= req_addr[1:0];
          cnt   <= '0;
          state <= bad ? ERR : WAIT;
          if (!bad) begin
            mem_valid <= 1'b1;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= req_store ? wd : '0;
            mem_wstrb <= req_store ? ws : 4'h0;
          end
        end
        WAIT: begin
          cnt <= cnt + 32'd1;
          if (mem_ready) begin
            resp_valid <= 1'b1;
            resp_rdata <= st ? '0 : ld;
            state      <= IDLE;
          end else if (tmo) begin
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            state      <= IDLE;
          end
        end
        ERR: begin
          resp_valid <= 1'b1;
          resp_error <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
- Memory-port initiator that drives the single-word valid/ready memory interface from the data side, one access at a time.
- Accepts byte, half and word load/store requests from the core's execute stage.
- Drives the 32-bit memory interface with word-aligned address, lane-replicated write data and byte strobes.
- Returns lane-extracted, sign- or zero-extended load data.
- Misaligned and illegal requests are rejected without touching memory; a watchdog converts a missing memory response into an error.

Parameters:
- TIMEOUT, 1024: cycles to wait for mem_ready after issue before returning an error response; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request (IDLE)
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  zero-extend load (1) or sign-extend (0)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  qualifies resp_valid: misaligned, illegal size, or timeout
- mem_valid  out  1  one-cycle access strobe to memory
- mem_instr  out  1  constant 0 (data access)
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte strobes; 0 for loads
- mem_rdata  in  32  memory read word, valid with mem_ready
- mem_ready  in  1  memory completion; asserted the cycle after mem_valid is sampled, or later

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE and the watchdog counter clears.
  - All outputs become 0, except req_ready = 1.
  - Reset mid-WAIT abandons the access; a later mem_ready is ignored.
- States: IDLE, WAIT, ERR.
- All mem_* and resp_* outputs are registered.
- Accept: at an edge where state = IDLE and req_valid = 1. The request fields are latched.
  - Misaligned or illegal requests go to ERR:
    - size = 1 with addr[0] = 1;
    - size = 2 with addr[1:0] != 0;
    - size = 3.
  - Otherwise the block goes to WAIT and drives mem_valid = 1 for exactly one cycle; the memory performs an access on every cycle it samples mem_valid high.
- Store encoding, with o = addr[1:0]:
  - byte: mem_wdata = {4{wdata[7:0]}}, mem_wstrb = 4'b0001 << o.
  - half: mem_wdata = {2{wdata[15:0]}}, mem_wstrb = 4'b0011 << o.
  - word: mem_wdata = wdata, mem_wstrb = 4'hF.
- Loads: mem_wstrb = 0 and mem_wdata = 0.
- WAIT:
  - mem_valid = 0. The counter increments each cycle.
  - On the edge where mem_ready = 1, the next cycle has resp_valid = 1 and resp_error = 0. For loads, resp_rdata = (mem_rdata >> 8*o), masked to size and sign/zero extended per req_unsigned. For stores, resp_rdata = 0. State returns to IDLE.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with no mem_ready: resp_valid = 1, resp_error = 1, state returns to IDLE.
  - If mem_ready arrives on the same edge as the timeout, ready wins.
- ERR: lasts one cycle. Emits resp_valid = 1, resp_error = 1, resp_rdata = 0. No mem_valid is ever asserted for the request. State returns to IDLE.
- req_ready = 1 only in IDLE, including the cycle in which resp_valid is high, so a new request can be accepted on the edge ending the response cycle.
- mem_ready seen in IDLE or ERR is ignored.
- Latency with a zero-wait memory:
  - request accepted at edge E0;
  - mem_valid high E0–E1;
  - mem_ready high E1–E2;
  - resp_valid high E2–E3.
- Throughput: one access per 3 cycles. Error response is 1 cycle after acceptance.
- mem_addr, mem_wdata and mem_wstrb hold their values from issue until the response; they are don't-care otherwise.

Test Plan:
- Word round trip:
  - store size=2, addr 0x100, wdata 0xDEADBEEF → one mem_valid pulse, mem_addr 0x100, wstrb 0xF, then resp_valid with error=0.
  - load 0x100 from zero-wait memory → resp_rdata 0xDEADBEEF exactly 2 cycles after acceptance.
- Byte sign extension: memory word 0x80FF1234.
  - signed byte load at 0x103 → 0xFFFFFF80.
  - unsigned byte load at 0x103 → 0x00000080.
  - unsigned byte load at 0x101 → 0x00000012.
- Half store lanes: store size=1, addr 0x102, wdata 0x0000ABCD → mem_wdata 0xABCDABCD, mem_wstrb 0xC, mem_addr 0x100. A following half load returns 0xFFFFABCD (signed).
- Misaligned and illegal: each of the following gives resp_valid and resp_error=1 one cycle after acceptance, with mem_valid never asserted:
  - word load at 0x102;
  - half store at 0x101;
  - size=3.
- Timeout, with TIMEOUT=8 and memory that never asserts mem_ready: a load gives resp_valid with error=1, 8 cycles after the mem_valid edge. req_ready is back to 1 and a subsequent normal access succeeds.
- Reset mid-WAIT: assert rst for 1 cycle while in WAIT, then have memory assert mem_ready → no resp_valid, all outputs 0, req_ready=1. The next request completes normally.
